// File: rtl/stream_lzc_if.sv
// Valid/ready stream bundle for stream_lzc: beat input channel and result output channel.
// beats_o is present only when STREAM_LZC_BEAT_COUNT_EN is defined.
interface stream_lzc_if #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned NUM_WORDS  = 4,
  parameter int unsigned CNT_WIDTH  = $clog2(WIDTH * NUM_WORDS),
  parameter int unsigned BEAT_WIDTH = $clog2(NUM_WORDS + 1)
);
  logic [WIDTH-1:0]     in_data_i;
  logic                 in_last_i;
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [CNT_WIDTH-1:0] cnt_o;
  logic                 empty_o;
  logic                 out_valid_o;
  logic                 out_ready_i;
`ifdef STREAM_LZC_BEAT_COUNT_EN
  logic [BEAT_WIDTH-1:0] beats_o;

  modport master (
    output in_data_i, in_last_i, in_valid_i, out_ready_i,
    input  in_ready_o, cnt_o, empty_o, out_valid_o, beats_o
  );
  modport slave (
    input  in_data_i, in_last_i, in_valid_i, out_ready_i,
    output in_ready_o, cnt_o, empty_o, out_valid_o, beats_o
  );
`else
  modport master (
    output in_data_i, in_last_i, in_valid_i, out_ready_i,
    input  in_ready_o, cnt_o, empty_o, out_valid_o
  );
  modport slave (
    input  in_data_i, in_last_i, in_valid_i, out_ready_i,
    output in_ready_o, cnt_o, empty_o, out_valid_o
  );
`endif
endinterface

// File: rtl/stream_lzc.sv
// Multi-beat leading/trailing zero counter over a valid/ready stream, one WIDTH-bit word per beat.
// Optional beat count output enabled by defining STREAM_LZC_BEAT_COUNT_EN.
module stream_lzc #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned NUM_WORDS = 4,
  parameter logic        MODE      = 1'b0,
  localparam int unsigned CNT_WIDTH = $clog2(WIDTH * NUM_WORDS)
) (
  input logic         clk_i,
  input logic         rst_ni,
  input logic         clear_i,
  stream_lzc_if.slave bus
);
  localparam int unsigned IDX_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned LOC_W  = $clog2(WIDTH);
  localparam int unsigned BEAT_W = $clog2(NUM_WORDS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [0:0] {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  // MODE 0: index of lowest set bit; MODE 1: zeros above the highest set bit.
  function automatic logic [LOC_W-1:0] local_count(input logic [WIDTH-1:0] data);
    logic [LOC_W-1:0] idx;
    idx = {LOC_W{1'b0}};
    if (MODE == 1'b0) begin
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
        if (data[i]) idx = LOC_W'(i);
      end
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (data[i]) idx = LOC_W'(i);
      end
      idx = LOC_W'(WIDTH - 1) - idx;
    end
    return idx;
  endfunction

  state_t               state_r;
  logic [IDX_W-1:0]     beat_idx_r;
  logic                 found_r;
  logic [CNT_WIDTH-1:0] acc_r;
  logic [CNT_WIDTH-1:0] cnt_r;
  logic                 empty_r;
  logic                 out_valid_r;

  logic                 in_ready_s;
  logic                 accept_s;
  logic                 close_s;
  logic [CNT_WIDTH-1:0] beat_cnt_s;
  logic [CNT_WIDTH-1:0] next_acc_s;
  logic                 next_found_s;

  assign in_ready_s = (state_r == ACCUM) | bus.out_ready_i;
  assign accept_s   = bus.in_valid_i & in_ready_s;
  assign close_s    = bus.in_last_i | (beat_idx_r == LAST_IDX);
  assign beat_cnt_s = CNT_WIDTH'(beat_idx_r) * CNT_WIDTH'(WIDTH)
                    + CNT_WIDTH'(local_count(bus.in_data_i));

  // The first set bit across the vector wins; later beats leave the count untouched.
  always_comb begin
    next_acc_s   = acc_r;
    next_found_s = found_r;
    if (found_r) begin
      next_acc_s   = acc_r;
      next_found_s = 1'b1;
    end else if (|bus.in_data_i) begin
      next_acc_s   = beat_cnt_s;
      next_found_s = 1'b1;
    end else begin
      next_acc_s   = {CNT_WIDTH{1'b0}};
      next_found_s = 1'b0;
    end
  end

`ifdef STREAM_LZC_BEAT_COUNT_EN
  logic [BEAT_W-1:0] beats_r;

  // Beat count of the completed vector, registered alongside cnt_o.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beats_r <= {BEAT_W{1'b0}};
    end else if (clear_i) begin
      beats_r <= {BEAT_W{1'b0}};
    end else if (accept_s && close_s) begin
      beats_r <= BEAT_W'(beat_idx_r) + BEAT_W'(1);
    end else begin
      beats_r <= beats_r;
    end
  end

  assign bus.beats_o = beats_r;
`endif

  // Accumulate beats in ACCUM, hold the result in HOLD; a closing beat accepted while the
  // pending result drains reloads HOLD directly.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= ACCUM;
      beat_idx_r  <= {IDX_W{1'b0}};
      found_r     <= 1'b0;
      acc_r       <= {CNT_WIDTH{1'b0}};
      cnt_r       <= {CNT_WIDTH{1'b0}};
      empty_r     <= 1'b1;
      out_valid_r <= 1'b0;
    end else if (clear_i) begin
      state_r     <= ACCUM;
      beat_idx_r  <= {IDX_W{1'b0}};
      found_r     <= 1'b0;
      acc_r       <= {CNT_WIDTH{1'b0}};
      cnt_r       <= {CNT_WIDTH{1'b0}};
      empty_r     <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      if (state_r == HOLD && bus.out_ready_i) begin
        state_r     <= ACCUM;
        out_valid_r <= 1'b0;
      end
      if (accept_s) begin
        if (close_s) begin
          beat_idx_r  <= {IDX_W{1'b0}};
          found_r     <= 1'b0;
          acc_r       <= {CNT_WIDTH{1'b0}};
          cnt_r       <= next_acc_s;
          empty_r     <= ~next_found_s;
          out_valid_r <= 1'b1;
          state_r     <= HOLD;
        end else begin
          beat_idx_r <= beat_idx_r + IDX_W'(1);
          found_r    <= next_found_s;
          acc_r      <= next_acc_s;
        end
      end
    end
  end

  assign bus.in_ready_o  = in_ready_s;
  assign bus.cnt_o       = cnt_r;
  assign bus.empty_o     = empty_r;
  assign bus.out_valid_o = out_valid_r;

endmodule

// File: tb/tb_stream_lzc.sv
// Directed scoreboard bench for stream_lzc: one trailing-zero (MODE=0) and one leading-zero
// (MODE=1) instance, WIDTH=8, NUM_WORDS=4.
module tb_stream_lzc;
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic clear_i = 1'b0;
  int   tests = 0;
  int   fails = 0;

  typedef struct packed {
    logic [4:0] cnt;
    logic       empty;
    logic [2:0] beats;
  } exp_t;

  exp_t q_tz[$];
  exp_t q_lz[$];

  stream_lzc_if #(.WIDTH(8), .NUM_WORDS(4)) tz_if ();
  stream_lzc_if #(.WIDTH(8), .NUM_WORDS(4)) lz_if ();

  stream_lzc #(.WIDTH(8), .NUM_WORDS(4), .MODE(1'b0)) u_tz (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .bus(tz_if.slave));
  stream_lzc #(.WIDTH(8), .NUM_WORDS(4), .MODE(1'b1)) u_lz (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .bus(lz_if.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: place words into a 32-bit vector and search the whole vector for the first set bit.
  function automatic exp_t model(input int sel, input logic [31:0] words, input int n);
    logic [31:0] v;
    exp_t e;
    v = 32'h0;
    for (int i = 0; i < n; i++) begin
      if (sel == 0) v[8*i +: 8] = words[8*i +: 8];
      else          v[8*(3-i) +: 8] = words[8*i +: 8];
    end
    e.cnt = 5'd0; e.empty = 1'b1; e.beats = 3'(n);
    if (sel == 0) begin
      for (int b = 31; b >= 0; b--) if (v[b]) begin e.cnt = 5'(b); e.empty = 1'b0; end
    end else begin
      for (int b = 0; b < 32; b++) if (v[b]) begin e.cnt = 5'(31 - b); e.empty = 1'b0; end
    end
    return e;
  endfunction

  task automatic set_in(input int sel, input logic v, input logic [7:0] d, input logic l);
    if (sel == 0) begin tz_if.in_valid_i = v; tz_if.in_data_i = d; tz_if.in_last_i = l; end
    else          begin lz_if.in_valid_i = v; lz_if.in_data_i = d; lz_if.in_last_i = l; end
  endtask

  // Present one beat, wait (bounded) for acceptance; returns just after the accepting edge.
  task automatic drive_beat(input int sel, input logic [7:0] d, input logic l);
    bit ok;
    ok = 1'b0;
    set_in(sel, 1'b1, d, l);
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      ok = (sel == 0) ? tz_if.in_ready_o : lz_if.in_ready_o;
      @(posedge clk); #1;
    end
    if (!ok) check("beat_accept_timeout", 32'd0, 32'd1);
    set_in(sel, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic send_vec(input int sel, input int n, input logic [31:0] words, input bit use_last);
    exp_t e;
    e = model(sel, words, n);
    for (int i = 0; i < n; i++) begin
      logic l;
      l = use_last && (i == n - 1);
      if (l || i == 3) begin
        if (sel == 0) q_tz.push_back(e); else q_lz.push_back(e);
      end
      drive_beat(sel, words[8*i +: 8], l);
    end
  endtask

  // Scoreboard: every consumed result must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_ni && tz_if.out_valid_o && tz_if.out_ready_i) begin
      if (q_tz.size() == 0) check("tz_unexpected_result", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q_tz.pop_front();
        check("tz_cnt", 32'(tz_if.cnt_o), 32'(e.cnt));
        check("tz_empty", 32'(tz_if.empty_o), 32'(e.empty));
`ifdef STREAM_LZC_BEAT_COUNT_EN
        check("tz_beats", 32'(tz_if.beats_o), 32'(e.beats));
`endif
      end
    end
    if (rst_ni && lz_if.out_valid_o && lz_if.out_ready_i) begin
      if (q_lz.size() == 0) check("lz_unexpected_result", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q_lz.pop_front();
        check("lz_cnt", 32'(lz_if.cnt_o), 32'(e.cnt));
        check("lz_empty", 32'(lz_if.empty_o), 32'(e.empty));
`ifdef STREAM_LZC_BEAT_COUNT_EN
        check("lz_beats", 32'(lz_if.beats_o), 32'(e.beats));
`endif
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(tz_if.out_valid_o), 32'd0);
    check({tag, "_cnt"}, 32'(tz_if.cnt_o), 32'd0);
    check({tag, "_empty"}, 32'(tz_if.empty_o), 32'd1);
    check({tag, "_ready"}, 32'(tz_if.in_ready_o), 32'd1);
`ifdef STREAM_LZC_BEAT_COUNT_EN
    check({tag, "_beats"}, 32'(tz_if.beats_o), 32'd0);
`endif
  endtask

  initial begin
    set_in(0, 1'b0, 8'h00, 1'b0);
    set_in(1, 1'b0, 8'h00, 1'b0);
    tz_if.out_ready_i = 1'b1;
    lz_if.out_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");
    check("reset_lz_valid", 32'(lz_if.out_valid_o), 32'd0);
    @(posedge clk); #1;

    // Test 1 and 2: MODE 0 basic and forced close of an all-zero vector
    send_vec(0, 4, 32'h00100000, 1'b1);
    send_vec(0, 4, 32'h00000000, 1'b0);
    // Test 3: MODE 1 short vector
    send_vec(1, 2, 32'h00000300, 1'b1);
    // Test 4: first set bit wins
    send_vec(0, 4, 32'hFFFF8001, 1'b1);
    // Extra patterns: set bit in the last word of each mode, forced close with nonzero data
    send_vec(0, 4, 32'h80000000, 1'b0);
    send_vec(1, 4, 32'h01000000, 1'b0);
    send_vec(1, 1, 32'h00000080, 1'b1);
    repeat (2) @(posedge clk); #1;

    // Test 5: backpressure holds the result and blocks input
    tz_if.out_ready_i = 1'b0;
    send_vec(0, 4, 32'h00100000, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_valid", 32'(tz_if.out_valid_o), 32'd1);
      check("bp_ready", 32'(tz_if.in_ready_o), 32'd0);
      check("bp_cnt", 32'(tz_if.cnt_o), 32'd20);
      check("bp_empty", 32'(tz_if.empty_o), 32'd0);
    end
    @(posedge clk); #1;
    tz_if.out_ready_i = 1'b1;
    send_vec(0, 1, 32'h00000004, 1'b1);
    @(negedge clk);
    check("bp_next_valid", 32'(tz_if.out_valid_o), 32'd1);
    check("bp_next_cnt", 32'(tz_if.cnt_o), 32'd2);
    @(posedge clk); #1;

    // Test 6a: clear mid-vector, with a beat offered in the clear cycle that must be dropped
    drive_beat(0, 8'h00, 1'b0);
    drive_beat(0, 8'h00, 1'b0);
    clear_i = 1'b1;
    set_in(0, 1'b1, 8'hFF, 1'b1);
    @(posedge clk); #1;
    clear_i = 1'b0;
    set_in(0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check("clear_valid", 32'(tz_if.out_valid_o), 32'd0);
    @(posedge clk); #1;
    send_vec(0, 2, 32'h00000200, 1'b1);
    repeat (2) @(posedge clk); #1;

    // Test 6b: reset pulsed mid-vector
    drive_beat(0, 8'h00, 1'b0);
    drive_beat(0, 8'h00, 1'b0);
    #2 rst_ni = 1'b0;
    #2;
    check_reset_outputs("midrst");
    @(posedge clk); #1 rst_ni = 1'b1;
    @(negedge clk);
    check_reset_outputs("postrst");
    @(posedge clk); #1;
    send_vec(0, 2, 32'h00000200, 1'b1);

    for (int c = 0; c < 20 && (q_tz.size() != 0 || q_lz.size() != 0); c++) @(posedge clk);
    @(negedge clk);
    check("tz_queue_drained", 32'(q_tz.size()), 32'd0);
    check("lz_queue_drained", 32'(q_lz.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
